// File: rtl/sprite_rle_loader.sv
// sprite_rle_loader: expands an RLE token stream into per-pixel sprite RAM writes.
// Optional SPRITE_RLE_TRANSPARENT_SKIP_EN suppresses writes for runs of TRANSP_COLOR.
module sprite_rle_loader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int RUN_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRANSP_COLOR = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [RUN_WIDTH-1:0]  tok_run,
  input  logic [DATA_WIDTH-1:0] tok_color,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
`ifdef SPRITE_RLE_TRANSPARENT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [ADDR_WIDTH:0] REM_ONE = 1;
  typedef enum logic [1:0] {IDLE, WAIT_TOK, EXPAND, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0] rem_q, rem_d;
  logic [RUN_WIDTH-1:0] run_q, run_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic ovr_q, ovr_d, accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      rem_q <= '0;
      run_q <= '0;
      color_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      run_q <= run_d;
      color_q <= color_d;
      ovr_q <= ovr_d;
    end
  // tok_ready in EXPAND looks only at registered counters so a new token chains with no bubble
  always_comb begin
    tok_ready = state_q == WAIT_TOK || (state_q == EXPAND && run_q == '0 && rem_q > REM_ONE);
    accept = tok_ready && tok_valid;
    busy = state_q != IDLE;
    done = state_q == DONE;
    we = state_q == EXPAND && !(SKIP_EN && color_q == TRANSP_COLOR);
    addr_w = ptr_q;
    din = color_q;
    overrun = ovr_q;
    state_d = state_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    run_d = run_q;
    color_d = color_q;
    ovr_d = ovr_q;
    case (state_q)
      IDLE:
        if (start) begin
          ptr_d = base_addr;
          rem_d = length;
          ovr_d = 1'b0;
          state_d = length == '0 ? DONE : WAIT_TOK;
        end
      WAIT_TOK:
        if (accept) begin
          color_d = tok_color;
          run_d = tok_run;
          state_d = EXPAND;
        end
      EXPAND: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        rem_d = rem_q - REM_ONE;
        run_d = run_q != '0 ? run_q - RUN_WIDTH'(1) : run_q;
        if (accept) begin
          color_d = tok_color;
          run_d = tok_run;
        end else if (rem_q == REM_ONE) begin
          ovr_d = run_q != '0;
          state_d = DONE;
        end else if (run_q == '0) state_d = WAIT_TOK;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sprite_rle_loader.sv
// tb_sprite_rle_loader: directed checks of RLE expansion, chaining, wrap, overrun, reset.
// Define SPRITE_RLE_TRANSPARENT_SKIP_EN for both bench and RTL to check the skip feature.
module tb_sprite_rle_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic tok_valid, tok_ready, we, busy, done, overrun;
  logic [7:0] tok_run;
  logic [11:0] tok_color, addr_w, din;
  logic [7:0] tq_run [32];
  logic [11:0] tq_col [32];
  int tq_n = 0, tq_i = 0, cyc = 0, wn = 0, dn = 0, dc = 0;
  int wc [128];
  logic [11:0] wa [128], wd [128];
  int total = 0, bad = 0, sc, w0, d0, to;

  sprite_rle_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_run(tok_run), .tok_color(tok_color),
    .we(we), .addr_w(addr_w), .din(din), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  assign tok_valid = tq_i < tq_n;
  assign tok_run = tq_run[tq_i[4:0]];
  assign tok_color = tq_col[tq_i[4:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tok_valid && tok_ready) tq_i <= tq_i + 1;
  end
  always @(negedge clk) begin
    if (we) begin
      wa[wn[6:0]] <= addr_w;
      wd[wn[6:0]] <= din;
      wc[wn[6:0]] <= cyc;
      wn <= wn + 1;
    end
    if (done) begin
      dn <= dn + 1;
      dc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [11:0] c);
    tq_run[tq_n[4:0]] = r;
    tq_col[tq_n[4:0]] = c;
    tq_n = tq_n + 1;
  endtask

  task automatic load(input logic [11:0] b, input logic [12:0] n);
    @(negedge clk); #1;
    start = 1'b1; base_addr = b; length = n;
    sc = cyc; w0 = wn; d0 = dn;
    @(negedge clk); #1;
    start = 1'b0;
    to = 0;
    while (dn == d0 && to < 600) begin
      @(negedge clk); #1;
      to++;
    end
    chk("done_timeout", 32'(to < 600), 1);
    repeat (2) @(negedge clk);
    #1;
    chk("done_once", dn - d0, 1);
    chk("tokens_drained", tq_i, tq_n);
  endtask

  initial begin
    #12;
    chk("rst_we", we, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_ready", tok_ready, 0); chk("rst_ovr", overrun, 0);
    chk("rst_addr", addr_w, 0); chk("rst_din", din, 0);
    @(negedge clk); rst_n = 1'b1;
    // single token fills the whole load
    push(8'd4, 12'hABC);
    load(12'h010, 13'd5);
    chk("t1_nwr", wn - w0, 5);
    chk("t1_lat", wc[w0[6:0]], sc + 2);
    for (int i = 0; i < 5; i++) begin
      chk("t1_addr", wa[(w0 + i) % 128], 12'h010 + i);
      chk("t1_din", wd[(w0 + i) % 128], 12'hABC);
      chk("t1_cyc", wc[(w0 + i) % 128], sc + 2 + i);
    end
    chk("t1_donecyc", dc, sc + 7);
    chk("t1_ovr", overrun, 0);
    // two chained tokens, no bubble
    push(8'd1, 12'h111); push(8'd3, 12'h222);
    load(12'h000, 13'd6);
    chk("t2_nwr", wn - w0, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_addr", wa[(w0 + i) % 128], i);
      chk("t2_din", wd[(w0 + i) % 128], i < 2 ? 12'h111 : 12'h222);
      chk("t2_cyc", wc[(w0 + i) % 128], sc + 2 + i);
    end
    // address wrap
    push(8'd3, 12'h00F);
    load(12'hFFE, 13'd4);
    chk("t3_nwr", wn - w0, 4);
    chk("t3_a0", wa[w0 % 128], 12'hFFE); chk("t3_a1", wa[(w0 + 1) % 128], 12'hFFF);
    chk("t3_a2", wa[(w0 + 2) % 128], 12'h000); chk("t3_a3", wa[(w0 + 3) % 128], 12'h001);
    // overrun then cleared by next start
    push(8'd7, 12'h0F0);
    load(12'h100, 13'd3);
    chk("t4_nwr", wn - w0, 3);
    chk("t4_din", wd[(w0 + 2) % 128], 12'h0F0);
    chk("t4_ovr", overrun, 1);
    push(8'd0, 12'h555);
    load(12'h200, 13'd1);
    chk("t4_nwr2", wn - w0, 1);
    chk("t4_ovr_clr", overrun, 0);
    // zero length
    load(12'h300, 13'd0);
    chk("t5_nwr", wn - w0, 0);
    chk("t5_donecyc", dc, sc + 1);
    // async reset mid-expand
    push(8'd9, 12'h777);
    @(negedge clk); #1;
    start = 1'b1; base_addr = 12'h100; length = 13'd10;
    @(negedge clk); #1;
    start = 1'b0;
    to = 0;
    while (!we && to < 50) begin
      @(negedge clk); #1;
      to++;
    end
    chk("t6_we_seen", we, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we", we, 0); chk("t6_busy", busy, 0); chk("t6_ready", tok_ready, 0);
    w0 = wn;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_nowr", wn - w0, 0); chk("t6_idle", busy, 0);
    // transparent run
    push(8'd1, 12'hF0F); push(8'd1, 12'h123);
    load(12'h020, 13'd4);
`ifdef SPRITE_RLE_TRANSPARENT_SKIP_EN
    chk("t7_nwr", wn - w0, 2);
    chk("t7_a0", wa[w0 % 128], 12'h022); chk("t7_a1", wa[(w0 + 1) % 128], 12'h023);
    chk("t7_d0", wd[w0 % 128], 12'h123); chk("t7_d1", wd[(w0 + 1) % 128], 12'h123);
`else
    chk("t7_nwr", wn - w0, 4);
    chk("t7_a0", wa[w0 % 128], 12'h020); chk("t7_d0", wd[w0 % 128], 12'hF0F);
    chk("t7_a3", wa[(w0 + 3) % 128], 12'h023); chk("t7_d3", wd[(w0 + 3) % 128], 12'h123);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
